// File: rtl/neural_pkg.sv
// rtl/neural_pkg.sv - shared types and constants for the neural layer sequencer
package neural_pkg;

    localparam int NEURONS      = 4;
    localparam int DATA_W_DEF   = 32;
    localparam int WEIGHT_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLOAD,
        S_WGAP,
        S_TRIG,
        S_WAIT,
        S_CAPT
    } state_t;

    // Flat weight table index: 16 entries per layer, 4 per neuron.
    function automatic int unsigned table_index(input int unsigned layer,
                                                input int unsigned neuron,
                                                input int unsigned inp);
        return layer * 16 + neuron * NEURONS + inp;
    endfunction

endpackage

// File: rtl/neural_weight_table.sv
// rtl/neural_weight_table.sv - weight register file, one write port, combinational read, no reset
module neural_weight_table #(
    parameter int DEPTH    = 32,
    parameter int WEIGHT_W = 8,
    parameter int AW       = 5
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [WEIGHT_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [WEIGHT_W-1:0] rdata
);

    logic [WEIGHT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/neural_layer_sequencer.sv
// rtl/neural_layer_sequencer.sv - streams weights/activations into NeuralUnit layer by layer
// Optional layerDone watchdog enabled by defining NEURAL_SEQ_TIMEOUT_EN.
module neural_layer_sequencer
    import neural_pkg::*;
#(
    parameter int  NUM_LAYERS     = 2,
    parameter int  DATA_W         = DATA_W_DEF,
    parameter int  WEIGHT_W       = WEIGHT_W_DEF,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int AW             = $clog2(NUM_LAYERS * 16),
    localparam int LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_W-1:0]   x0,
    input  logic [DATA_W-1:0]   x1,
    input  logic [DATA_W-1:0]   x2,
    input  logic [DATA_W-1:0]   x3,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   result0,
    output logic [DATA_W-1:0]   result1,
    output logic [DATA_W-1:0]   result2,
    output logic [DATA_W-1:0]   result3,
    output logic [DATA_W-1:0]   nu_input0,
    output logic [DATA_W-1:0]   nu_input1,
    output logic [DATA_W-1:0]   nu_input2,
    output logic [DATA_W-1:0]   nu_input3,
    output logic [WEIGHT_W-1:0] nu_weight,
    output logic [1:0]          nu_address,
    output logic                nu_write,
    output logic                nu_sumTrigger,
    output logic                nu_layer_Sel,
    input  logic [DATA_W-1:0]   nu_layerOut,
    input  logic                nu_layerDone
);

    if (NUM_LAYERS < 1 || NUM_LAYERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("neural_layer_sequencer: parameter out of range");
    end

    state_t              state, state_n;
    logic [LW-1:0]       layer, layer_n;
    logic [1:0]          neuron, neuron_n, inp, inp_n;
    logic                ld_q, ld_rise, timeout, last_layer, last_neuron;
    logic                busy_n, write_n, trig_n, sel_n, done_n;
    logic [DATA_W-1:0]   cap_buf [3];
    logic [AW-1:0]       rd_addr;
    logic [WEIGHT_W-1:0] rd_data;

    assign last_layer  = (layer == LW'(NUM_LAYERS - 1));
    assign last_neuron = (neuron == 2'(NEURONS - 1));
    assign ld_rise     = nu_layerDone & ~ld_q;
    // Read addressed by the counters being entered so the weight register loads with WLOAD.
    assign rd_addr     = AW'(table_index(32'(layer_n), 32'(neuron_n), 32'(inp_n)));

    neural_weight_table #(
        .DEPTH   (NUM_LAYERS * 16),
        .WEIGHT_W(WEIGHT_W),
        .AW      (AW)
    ) u_table (
        .clk  (clk),
        .we   (cfg_we && (state == S_IDLE)),
        .waddr(cfg_addr),
        .wdata(cfg_wdata),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            layer  <= '0;
            neuron <= '0;
            inp    <= '0;
        end else begin
            state  <= state_n;
            layer  <= layer_n;
            neuron <= neuron_n;
            inp    <= inp_n;
        end
    end

    always_comb begin
        state_n  = state;
        layer_n  = layer;
        neuron_n = neuron;
        inp_n    = inp;
        case (state)
            S_IDLE: if (start) begin
                state_n  = S_WLOAD;
                layer_n  = '0;
                neuron_n = '0;
                inp_n    = '0;
            end
            S_WLOAD: state_n = S_WGAP;
            S_WGAP: begin
                if (inp == 2'd3) begin
                    state_n = S_TRIG;
                end else begin
                    state_n = S_WLOAD;
                    inp_n   = inp + 2'd1;
                end
            end
            S_TRIG: state_n = S_WAIT;
            S_WAIT: begin
                if (ld_rise)      state_n = S_CAPT;
                else if (timeout) state_n = S_IDLE;
            end
            S_CAPT: begin
                inp_n = '0;
                if (!last_neuron) begin
                    neuron_n = neuron + 2'd1;
                    state_n  = S_WLOAD;
                end else if (!last_layer) begin
                    layer_n  = layer + LW'(1);
                    neuron_n = '0;
                    state_n  = S_WLOAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy_n  = (state_n != S_IDLE);
        write_n = (state_n == S_WLOAD);
        trig_n  = (state_n == S_TRIG);
        sel_n   = (layer_n != LW'(NUM_LAYERS - 1));
        done_n  = (state == S_CAPT) && last_neuron && last_layer;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_q          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            nu_write      <= 1'b0;
            nu_sumTrigger <= 1'b0;
            nu_layer_Sel  <= 1'b1;
            nu_weight     <= '0;
            nu_address    <= '0;
            nu_input0     <= '0;
            nu_input1     <= '0;
            nu_input2     <= '0;
            nu_input3     <= '0;
            result0       <= '0;
            result1       <= '0;
            result2       <= '0;
            result3       <= '0;
            for (int i = 0; i < 3; i++) cap_buf[i] <= '0;
        end else begin
            ld_q          <= nu_layerDone;
            busy          <= busy_n;
            done          <= done_n;
            nu_write      <= write_n;
            nu_sumTrigger <= trig_n;
            nu_layer_Sel  <= sel_n;
            if (write_n) begin
                nu_weight  <= rd_data;
                nu_address <= inp_n;
            end
            if ((state == S_IDLE) && start) begin
                nu_input0 <= x0;
                nu_input1 <= x1;
                nu_input2 <= x2;
                nu_input3 <= x3;
            end
            // Neuron 3's output comes straight from the unit; the first three are buffered.
            if (state == S_CAPT) begin
                if (!last_neuron) begin
                    cap_buf[neuron] <= nu_layerOut;
                end else if (!last_layer) begin
                    nu_input0 <= cap_buf[0];
                    nu_input1 <= cap_buf[1];
                    nu_input2 <= cap_buf[2];
                    nu_input3 <= nu_layerOut;
                end else begin
                    result0 <= cap_buf[0];
                    result1 <= cap_buf[1];
                    result2 <= cap_buf[2];
                    result3 <= nu_layerOut;
                end
            end
        end
    end

`ifdef NEURAL_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          err_q;

    assign timeout = (state == S_WAIT) && !ld_rise && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
            if (timeout)                         err_q <= 1'b1;
            else if ((state == S_IDLE) && start) err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// tb/tb_neural_layer_sequencer.sv - randomized self-checking bench with a NeuralUnit model and reference network
module tb_neural_layer_sequencer;

    localparam int NL = 2;
    localparam int DW = 32;
    localparam int WW = 8;
    localparam int AW = $clog2(NL * 16);
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset, start, cfg_we;
    logic [DW-1:0] x0, x1, x2, x3;
    logic [AW-1:0] cfg_addr;
    logic [WW-1:0] cfg_wdata;
    logic          busy, done, err;
    logic [DW-1:0] result0, result1, result2, result3;
    logic [DW-1:0] nu_input0, nu_input1, nu_input2, nu_input3;
    logic [WW-1:0] nu_weight;
    logic [1:0]    nu_address;
    logic          nu_write, nu_sumTrigger, nu_layer_Sel;
    logic [DW-1:0] nu_layerOut;
    logic          nu_layerDone;

    always #5 clk = ~clk;

    neural_layer_sequencer #(
        .NUM_LAYERS(NL), .DATA_W(DW), .WEIGHT_W(WW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .busy(busy), .done(done), .err(err),
        .result0(result0), .result1(result1), .result2(result2), .result3(result3),
        .nu_input0(nu_input0), .nu_input1(nu_input1), .nu_input2(nu_input2), .nu_input3(nu_input3),
        .nu_weight(nu_weight), .nu_address(nu_address), .nu_write(nu_write),
        .nu_sumTrigger(nu_sumTrigger), .nu_layer_Sel(nu_layer_Sel),
        .nu_layerOut(nu_layerOut), .nu_layerDone(nu_layerDone)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [4*DW-1:0] got, input logic [4*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference network: weights table and per-layer activation vectors {a3,a2,a1,a0}
    logic [WW-1:0]   tbl [NL*16];
    logic [4*DW-1:0] exp_in [NL+1];

    function automatic logic [4*DW-1:0] ref_layer(input int l, input logic [4*DW-1:0] v);
        logic [4*DW-1:0] o;
        logic [DW-1:0]   acc;
        o = '0;
        for (int n = 0; n < 4; n++) begin
            acc = '0;
            for (int i = 0; i < 4; i++) acc = acc + v[i*DW +: DW] * DW'(tbl[l*16 + n*4 + i]);
            o[n*DW +: DW] = acc;
        end
        return o;
    endfunction

    // NeuralUnit model: latches written weights, sums on trigger, raises layerDone later
    bit            mon_en = 1'b0;
    bit            m_spur = 1'b0, m_hold = 1'b0, m_never = 1'b0;
    int            trig_cnt = 0, wcnt = 0, cd = 0;
    bit            hold_hi = 1'b0, prev_write = 1'b0, ld;
    logic [WW-1:0] uw [4];
    logic [DW-1:0] pend_out;

    initial begin
        nu_layerDone = 1'b0;
        nu_layerOut  = '0;
        forever begin
            @(negedge clk);
            ld = 1'b0;
            if (reset) begin
                cd = 0; wcnt = 0; hold_hi = 1'b0; prev_write = 1'b0;
            end else begin
                if (nu_write) begin
                    if (mon_en) begin
                        check("write_spacing", prev_write, 0);
                        check("write_address", nu_address, wcnt % 4);
                        if (trig_cnt / 4 < NL)
                            check("inputs_at_write", {nu_input3, nu_input2, nu_input1, nu_input0}, exp_in[trig_cnt/4]);
                    end
                    uw[nu_address] = nu_weight;
                    if (m_spur && wcnt == 0) begin ld = 1'b1; nu_layerOut = $urandom; end
                    if (m_hold && wcnt == 3) begin hold_hi = 1'b1; nu_layerOut = $urandom; end
                    wcnt++;
                end
                if (nu_sumTrigger) begin
                    if (mon_en && trig_cnt / 4 < NL) begin
                        int b;
                        b = (trig_cnt / 4) * 16 + (trig_cnt % 4) * 4;
                        check("writes_per_neuron", wcnt, 4);
                        check("layer_sel", nu_layer_Sel, (trig_cnt / 4) != NL - 1);
                        check("neuron_weights", {uw[3], uw[2], uw[1], uw[0]}, {tbl[b+3], tbl[b+2], tbl[b+1], tbl[b]});
                    end
                    pend_out = nu_input0 * DW'(uw[0]) + nu_input1 * DW'(uw[1])
                             + nu_input2 * DW'(uw[2]) + nu_input3 * DW'(uw[3]);
                    cd = m_never ? 0 : (m_hold ? 4 : 3);
                    wcnt = 0;
                    trig_cnt++;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 2) hold_hi = 1'b0;
                    if (cd == 0) begin ld = 1'b1; nu_layerOut = pend_out; end
                end
                prev_write = nu_write;
            end
            nu_layerDone = ld | hold_hi;
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_write", nu_write, 0);
        check("rst_trigger", nu_sumTrigger, 0);
        check("rst_layer_sel", nu_layer_Sel, 1);
        check("rst_weight", nu_weight, 0);
        check("rst_address", nu_address, 0);
        check("rst_inputs", {nu_input3, nu_input2, nu_input1, nu_input0}, 0);
        check("rst_results", {result3, result2, result1, result0}, 0);
    endtask

    task automatic load_table(input bit by_index);
        for (int i = 0; i < NL * 16; i++) begin
            @(negedge clk);
            cfg_we    = 1'b1;
            cfg_addr  = AW'(i);
            cfg_wdata = by_index ? WW'(i) : WW'($urandom);
            tbl[i]    = cfg_wdata;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic launch(input logic [4*DW-1:0] xv);
        exp_in[0] = xv;
        for (int l = 0; l < NL; l++) exp_in[l+1] = ref_layer(l, exp_in[l]);
        trig_cnt = 0;
        wcnt     = 0;
        @(negedge clk);
        {x3, x2, x1, x0} = xv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_clear_on_start", err, 0);
    endtask

    task automatic do_run(input logic [4*DW-1:0] xv, input int wlen, input bit inject);
        int cyc;
        bit seen;
        launch(xv);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 2000) begin
            if (done) begin seen = 1'b1; break; end
            if (inject) begin
                if (cyc == 2)  begin cfg_we = 1'b1; cfg_addr = AW'(5); cfg_wdata = 8'hFF; end
                if (cyc == 3)  cfg_we = 1'b0;
                if (cyc == 60) begin start = 1'b1; {x3, x2, x1, x0} = {$urandom, $urandom, $urandom, $urandom}; end
                if (cyc == 61) start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", seen, 1);
        check("latency", cyc, NL * 4 * (10 + wlen));
        check("busy_at_done", busy, 0);
        check("results", {result3, result2, result1, result0}, exp_in[NL]);
        @(negedge clk);
        check("done_single_cycle", done, 0);
        check("results_hold", {result3, result2, result1, result0}, exp_in[NL]);
        check("err_low", err, 0);
    endtask

    logic [4*DW-1:0] xr;

    initial begin
        reset = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        {x3, x2, x1, x0} = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        load_table(1'b1);
        do_run({32'd3, 32'd2, 32'd1, 32'd0}, 3, 1'b0);

        for (int r = 0; r < 4; r++) begin
            load_table(1'b0);
            m_spur = r[0];
            m_hold = r[1];
            xr = {$urandom, $urandom, $urandom, $urandom};
            do_run(xr, m_hold ? 4 : 3, 1'b0);
        end
        m_spur = 1'b0;
        m_hold = 1'b0;

        // start and cfg writes while busy must not disturb the run or the table
        xr = {$urandom, $urandom, $urandom, $urandom};
        do_run(xr, 3, 1'b1);
        do_run(xr, 3, 1'b0);

        // reset during WAIT of layer 1, neuron 2
        begin
            int cyc;
            launch({$urandom, $urandom, $urandom, $urandom});
            cyc = 0;
            while (trig_cnt < 7 && cyc < 500) begin @(negedge clk); #1; cyc++; end
            check("abort_reached", trig_cnt, 7);
            @(negedge clk); #1;
            check("abort_busy", busy, 1);
            reset = 1'b1;
            #1;
            check_reset_vals();
            @(negedge clk); #1;
            reset = 1'b0;
        end
        do_run({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0);

`ifdef NEURAL_SEQ_TIMEOUT_EN
        begin
            int cyc;
            bit saw_done;
            m_never = 1'b1;
            launch({$urandom, $urandom, $urandom, $urandom});
            cyc = 0;
            saw_done = 1'b0;
            while (!err && cyc < 500) begin
                @(negedge clk);
                cyc++;
                if (done) saw_done = 1'b1;
            end
            check("timeout_latency", cyc, 8 + 1 + TO);
            check("timeout_err", err, 1);
            check("timeout_busy", busy, 0);
            check("timeout_no_done", saw_done, 0);
            m_never = 1'b0;
            do_run({$urandom, $urandom, $urandom, $urandom}, 3, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/neural_layer_sequencer.md
# neural_layer_sequencer

Upstream controller for `NeuralUnit`. It holds the weight table for a small fully connected network of 4 neurons per layer. For every neuron of every layer it streams the four 8-bit weights into the unit, fires `sumTrigger`, waits for `layerDone`, and captures `layerOut`. Each completed layer's four outputs become the next layer's inputs, and the final layer's outputs are presented as the inference result.

## Interface
- `NUM_LAYERS`, default 2: layers per inference, range 1..8.
- `DATA_W`, default 32: activation width, which matches `NeuralUnit` inputs and `layerOut`.
- `WEIGHT_W`, default 8: weight width.
- `TIMEOUT_CYCLES`, default 1024: `layerDone` watchdog limit. Used only with `NEURAL_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin an inference on `x0..x3`.
- `x0`, `x1`, `x2`, `x3` in DATA_W: sample vector, captured on accepted `start`.
- `cfg_we` in 1: weight table write strobe.
- `cfg_addr` in clog2(NUM_LAYERS*16): table index = layer*16 + neuron*4 + input.
- `cfg_wdata` in WEIGHT_W: weight value.
- `busy` out 1: high from accepted `start` until `done`/`err`.
- `done` out 1: one-cycle pulse when `result0..3` are valid.
- `err` out 1: timeout flag. Constant 0 without the macro.
- `result0..3` out DATA_W: last layer outputs; hold until the next `done`.
- `nu_input0..3` out DATA_W: to `NeuralUnit` `input0..3`.
- `nu_weight` out WEIGHT_W, `nu_address` out 2, `nu_write` out 1: weight load into the unit.
- `nu_sumTrigger` out 1, `nu_layer_Sel` out 1: to `sumTrigger`, `layer_Sel`.
- `nu_layerOut` in DATA_W, `nu_layerDone` in 1: from the unit.

## Operation
- States:
  - IDLE: waits for `start`.
  - WLOAD: `nu_write`=1 for one cycle.
  - WGAP: `nu_write`=0 for one cycle. `nu_weight`/`nu_address` are held through both.
  - TRIG: `nu_sumTrigger`=1 for one cycle.
  - WAIT: waits for the `layerDone` edge.
  - CAPT: stores `nu_layerOut` into `buf[neuron]` and advances the counters.
- In IDLE, `start` latches `x0..x3` into `buf` and clears the layer, neuron and input counters. The FSM then goes to WLOAD.
- WLOAD↔WGAP repeats for inputs 0..3, using weight `table[layer][neuron][input]` and `nu_address`=input. After the input-3 WGAP the FSM goes to TRIG, then WAIT.
- WAIT exits on a rising edge of `nu_layerDone`, detected against a registered copy. A level that is already high does not count. Rising edges in any other state are ignored.
- CAPT:
  - If neuron < 3: neuron+1, go to WLOAD.
  - Else, for a non-final layer: copy the captured outputs into `nu_input0..3` for the next layer, then layer+1, neuron=0, go to WLOAD.
  - Else (final layer): copy the outputs to `result0..3`, pulse `done`, go to IDLE.
- `nu_input0..3` are driven from the current-layer input register. They change only at layer boundaries, so they are stable while a layer's neurons run.
- `nu_layer_Sel`=1 for every layer except the last, and 0 for the last layer.
- `start` while `busy` is ignored.
- `cfg_we` while `busy` is ignored, so the table is frozen during inference. In IDLE a write takes effect at the clock edge.
- The weight table is not reset. Contents are retained across `reset` and are undefined until written.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `nu_write`=0, `nu_sumTrigger`=0, `nu_layer_Sel`=1, `nu_weight`=0, `nu_address`=0, `nu_input0..3`=0, `result0..3`=0. State = IDLE.
- Cost per neuron: 8 load cycles + 1 TRIG + W + 1 CAPT, where W is the number of WAIT cycles until the edge is seen (registered detection, W ≥ 1).
- Inference latency from accepted `start` to `done` = NUM_LAYERS × 4 × (10 + W). `done` is registered.
- All outputs to `NeuralUnit` are registered, with no combinational path from `nu_*` inputs.
- `reset` mid-inference: immediate return to IDLE with reset values. Partial results are discarded. The table is retained.
- When `done` asserts, `busy` falls in the same cycle. A `start` in the following cycle is accepted.

## Configuration
- `NEURAL_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - After `TIMEOUT_CYCLES` cycles without an edge, the FSM sets `err`=1, clears `busy`, goes to IDLE, and does not pulse `done`.
  - `err` stays high until the next accepted `start` or `reset`.
- Not defined: WAIT is unbounded and `err` is tied to 0.

## Structure
- Shared package `neural_pkg`:
  - State enum.
  - `DATA_W`/`WEIGHT_W` defaults.
  - Neurons-per-layer constant 4.
  - Table index helper function.
- One sub-module, `neural_weight_table`: NUM_LAYERS*16 × WEIGHT_W register file with a write port and a combinational read port, no reset. The FSM, counters and buffers stay in the top.

## Test plan
- Table load with weight = index (0..31), NUM_LAYERS=2, then `start` with x=0,1,2,3. A bench `NeuralUnit` model (`layerDone` 3 cycles after `sumTrigger`) must see `nu_address` 0,1,2,3 with `nu_weight` 0,1,2,3 for neuron 0, each write exactly one cycle high followed by one low. `done` must arrive after 2×4×(10+W) cycles, and `result0..3` must match the model.
- Layer handoff: `nu_input0..3` must equal layer-0 captured outputs throughout layer 1. `nu_layer_Sel` must be 1 in layer 0 and 0 in layer 1.
- `layerDone` held high across TRIG, and a spurious pulse during WLOAD: neither advances the FSM. Only a fresh rising edge in WAIT captures.
- `start` and `cfg_we` (addr 5, data 0xFF) during busy: both are ignored. Table entry 5 is unchanged and the results are identical to a clean run.
- `reset` asserted in WAIT of layer 1, neuron 2: all outputs return to reset values asynchronously. A new `start` reruns correctly using the retained weights.
- With `NEURAL_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES=16: the model never asserts `layerDone`. `err` must rise after 16 WAIT cycles, `busy` must fall, and no `done` pulse occurs. The next `start` clears `err`.
